// File: rtl/spi_slave_rx.sv
// SPI slave receiver (mode 0, LSB first). Oversamples SCK/CS/MOSI in the
// system clock domain, assembles one address byte and one data byte per
// chip-select window, and hands the pair downstream over valid/ready.
//
// Downstream handshake: rx_addr/rx_data are meaningful while rx_valid is 1.
// They stay stable until a cycle with rx_valid & rx_ready. rx_valid then drops
// on the next cycle, unless a new frame completes in that same cycle, in which
// case the new pair loads and rx_valid stays high.
module spi_slave_rx #(
  parameter int DSIZE       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             spi_clk,
  input  logic             reset,
  input  logic             spi_sck,
  input  logic             spi_cs,
  input  logic             spi_mosi_in,
  output logic [DSIZE-1:0] rx_addr,
  output logic [DSIZE-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic [1:0]       dbg_state
);

  localparam int CW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DSIZE - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ADDR    = 2'd1;
  localparam logic [1:0] ST_DATA    = 2'd2;
  localparam logic [1:0] ST_WAIT_CS = 2'd3;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, cs_fall, cs_rise;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DSIZE-1:0] addr_sh_q, addr_sh_d;
  logic [DSIZE-1:0] data_sh_q, data_sh_d;
  logic [DSIZE-1:0] rx_addr_q, rx_addr_d;
  logic [DSIZE-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  // Synchroniser chains plus one history flop per line for edge detection;
  // reset loads the idle bus levels so no spurious edge follows reset.
  always_ff @(posedge spi_clk) begin
    if (reset) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_in};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;

  // Frame FSM, bit assembly and output slot management.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    rx_addr_d   = rx_addr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_ADDR;
          bit_cnt_d = '0;
        end
      end
      ST_ADDR: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (sck_rise) begin
          addr_sh_d[bit_cnt_q] = mosi_s;
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      ST_DATA: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (sck_rise) begin
          data_sh_d[bit_cnt_q] = mosi_s;
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = ST_WAIT_CS;
            bit_cnt_d = '0;
            // Slot is busy only if the held frame is not leaving this cycle.
            if (rx_valid_q && !rx_ready) begin
              overrun_d = 1'b1;
            end else begin
              rx_addr_d  = addr_sh_d;
              rx_data_d  = data_sh_d;
              rx_valid_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: begin
        if (cs_s) state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge spi_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      rx_addr_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      rx_addr_q   <= rx_addr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_addr   = rx_addr_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed scenarios plus random frames, with a
// bit-stream reference model and a scoreboard of accepted address/data pairs.
module tb_spi_slave_rx;

  localparam int DSIZE = 8;
  localparam int S     = 2;

  logic             clk = 1'b0;
  logic             reset, sck, cs, mosi, rx_ready;
  logic [DSIZE-1:0] rx_addr, rx_data;
  logic             rx_valid, frame_err, overrun;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  spi_slave_rx #(.DSIZE(DSIZE), .SYNC_STAGES(S)) dut (
    .spi_clk(clk), .reset(reset), .spi_sck(sck), .spi_cs(cs),
    .spi_mosi_in(mosi), .rx_addr(rx_addr), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // Monitor: counts pulse/valid cycles and records every accepted pair.
  int          fe_cnt = 0, ov_cnt = 0, vcyc = 0, got_wr = 0;
  logic [15:0] got_mem [256];
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid) vcyc++;
      if (rx_valid && rx_ready && got_wr < 256) begin
        got_mem[got_wr] = {rx_addr, rx_data};
        got_wr++;
      end
    end
  end

  logic [15:0] exp_q[$];
  bit          stim_q[$];
  int          got_rd = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: the pair is the first 2*DSIZE serial bits, LSB first.
  function automatic logic [15:0] model_pair();
    int a = 0, d = 0;
    for (int i = 0; i < DSIZE; i++) begin
      a = a + int'(stim_q[i]) * (1 << i);
      d = d + int'(stim_q[DSIZE + i]) * (1 << i);
    end
    return {a[7:0], d[7:0]};
  endfunction

  // Sends a complete frame; optionally raises rx_ready exactly in the
  // completion cycle (last SCK rise seen S+1 edges after the pin change).
  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input int junk,
                            input bit ready_late, input bit expect_accept);
    stim_q.delete();
    for (int i = 0; i < DSIZE; i++) stim_q.push_back(a[i]);
    for (int i = 0; i < DSIZE; i++) stim_q.push_back(d[i]);
    for (int i = 0; i < junk; i++) stim_q.push_back(1'($urandom_range(0, 1)));
    if (expect_accept) exp_q.push_back(model_pair());
    cs = 1'b0;
    tick(4);
    for (int i = 0; i < stim_q.size(); i++) begin
      mosi = stim_q[i];
      sck  = 1'b0;
      tick(4);
      sck = 1'b1;
      if (ready_late && i == 2 * DSIZE - 1) begin
        tick(S);
        rx_ready = 1'b1;
        tick(1);
        chk("t4_addr", rx_addr, a);
        chk("t4_data", rx_data, d);
        chk("t4_valid", rx_valid, 1);
        chk("t4_overrun", overrun, 0);
        tick(3 - S);
      end else begin
        tick(4);
      end
    end
    sck = 1'b0;
    tick(4);
    cs = 1'b1;
    tick(6);
  endtask

  task automatic check_sb();
    chk("sb_count", got_wr - got_rd, exp_q.size());
    while (exp_q.size() > 0 && got_rd < got_wr) begin
      chk("sb_pair", got_mem[got_rd], exp_q.pop_front());
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_wr;
  endtask

  int fe0, ov0, v0;

  initial begin
    reset = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0; rx_ready = 1'b0;
    tick(5);
    chk("rst_addr", rx_addr, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    tick(4);

    // 1: basic frame, single-cycle valid
    rx_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcyc;
    send_frame(8'hA5, 8'h3C, 0, 0, 1);
    chk("t1_addr", rx_addr, 8'hA5);
    chk("t1_data", rx_data, 8'h3C);
    chk("t1_vcyc", vcyc - v0, 1);
    chk("t1_ferr", fe_cnt - fe0, 0);
    chk("t1_ovr", ov_cnt - ov0, 0);
    check_sb();

    // 2: CS released after 5 address bits
    fe0 = fe_cnt; v0 = vcyc;
    cs = 1'b0;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'($urandom_range(0, 1)); sck = 1'b0; tick(4); sck = 1'b1; tick(4);
    end
    sck = 1'b0; tick(4); cs = 1'b1; tick(8);
    chk("t2_ferr", fe_cnt - fe0, 1);
    chk("t2_vcyc", vcyc - v0, 0);
    chk("t2_addr_kept", rx_addr, 8'hA5);
    chk("t2_data_kept", rx_data, 8'h3C);
    send_frame(8'h01, 8'hFF, 0, 0, 1);
    check_sb();

    // 3: slot held, second frame overruns
    rx_ready = 1'b0;
    send_frame(8'h11, 8'h22, 0, 0, 1);
    chk("t3_valid", rx_valid, 1);
    ov0 = ov_cnt;
    send_frame(8'h33, 8'h44, 0, 0, 0);
    chk("t3_ovr", ov_cnt - ov0, 1);
    chk("t3_addr", rx_addr, 8'h11);
    chk("t3_data", rx_data, 8'h22);
    chk("t3_valid_held", rx_valid, 1);
    rx_ready = 1'b1;
    tick(1);
    chk("t3_valid_drop", rx_valid, 0);
    check_sb();

    // 4: ready arrives in the completion cycle of the second frame
    rx_ready = 1'b0;
    send_frame(8'h11, 8'h22, 0, 0, 1);
    ov0 = ov_cnt;
    send_frame(8'h33, 8'h44, 0, 1, 1);
    chk("t4_ovr_cnt", ov_cnt - ov0, 0);
    check_sb();

    // 5: reset in the middle of the data byte
    rx_ready = 1'b1;
    fe0 = fe_cnt;
    cs = 1'b0;
    tick(4);
    for (int i = 0; i < DSIZE + 3; i++) begin
      mosi = 1'($urandom_range(0, 1)); sck = 1'b0; tick(4); sck = 1'b1; tick(4);
    end
    reset = 1'b1;
    tick(2);
    cs = 1'b1; sck = 1'b0;
    tick(4);
    chk("t5_addr", rx_addr, 0);
    chk("t5_data", rx_data, 0);
    chk("t5_valid", rx_valid, 0);
    chk("t5_ferr_pin", frame_err, 0);
    reset = 1'b0;
    tick(6);
    chk("t5_ferr", fe_cnt - fe0, 0);
    send_frame(8'h5A, 8'hC3, 0, 0, 1);
    check_sb();

    // 6: 4 extra SCK pulses in one window
    v0 = vcyc;
    send_frame(8'h80, 8'h01, 4, 0, 1);
    chk("t6_vcyc", vcyc - v0, 1);
    chk("t6_addr", rx_addr, 8'h80);
    chk("t6_data", rx_data, 8'h01);
    check_sb();

    // Random frames with random trailing junk
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int n = 0; n < 20; n++) begin
      send_frame(8'($urandom), 8'($urandom), $urandom_range(0, 3), 0, 1);
    end
    check_sb();
    chk("rnd_ferr", fe_cnt - fe0, 0);
    chk("rnd_ovr", ov_cnt - ov0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
